// File: rtl/lcd_scanout_pkg.sv
// Shared definitions for the LCD scan-out block: state encoding, panel
// geometry defaults and the CRC-8 byte step used by the optional frame
// checksum (LCD_SCANOUT_CRC_EN).
package lcd_scanout_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        CAPTURE = 3'd2,
        OUT     = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam int LCD_WIDTH = 96;
    localparam int LCD_PAGES = 8;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One byte of CRC-8, MSB first: fold the byte in, then shift eight times.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/lcd_scanout_crc8_update.sv
// Combinational CRC-8 step: next CRC from the running CRC and one byte.
// Only present when LCD_SCANOUT_CRC_EN is defined; without the macro this
// file contributes nothing to the build.
`ifdef LCD_SCANOUT_CRC_EN
module lcd_scanout_crc8_update
    import lcd_scanout_pkg::*;
(
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] crc_next
);

    assign crc_next = crc8_byte(crc, data);

endmodule
`endif

// File: rtl/lcd_scanout.sv
// LCD scan-out: on each frame_complete pulse, walks the controller display
// RAM page by page, captures each column byte and streams it with its
// framebuffer address over a valid/ready handshake. One extra frame request
// can be queued during a scan; further requests are counted as dropped.
// Optional macro LCD_SCANOUT_CRC_EN adds a CRC-8 over each frame's bytes.
module lcd_scanout
    import lcd_scanout_pkg::*;
#(
    parameter int WIDTH  = LCD_WIDTH,
    parameter int PAGES  = LCD_PAGES,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              clk_ce,
    input  logic              reset,
    input  logic              frame_complete,
    output logic [6:0]        lcd_read_x,
    output logic [4:0]        lcd_read_y,
    input  logic [7:0]        lcd_read_column,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [7:0]        frames_dropped
`ifdef LCD_SCANOUT_CRC_EN
    ,
    output logic [7:0]        frame_crc,
    output logic              frame_crc_valid
`endif
);

    localparam logic [6:0] X_LAST    = 7'(WIDTH - 1);
    localparam logic [2:0] PAGE_LAST = 3'(PAGES - 1);

    state_e            state_r;
    logic [6:0]        x_r;
    logic [2:0]        page_r;
    logic [6:0]        lcd_x_r;
    logic [2:0]        lcd_page_r;
    logic [7:0]        data_r;
    logic [ADDR_W-1:0] addr_r;
    logic              valid_r;
    logic              last_r;
    logic              busy_r;
    logic              pending_r;
    logic [7:0]        drop_cnt_r;

    logic              in_scan_s;
    logic              restart_s;
    logic              scan_start_s;
    logic              pending_set_s;
    logic              drop_s;
    logic              is_last_s;
    logic [ADDR_W-1:0] addr_s;

    assign lcd_read_x     = lcd_x_r;
    assign lcd_read_y     = {2'b00, lcd_page_r};
    assign out_data       = data_r;
    assign out_addr       = addr_r;
    assign out_valid      = valid_r;
    assign out_last       = last_r;
    assign busy           = busy_r;
    assign frames_dropped = drop_cnt_r;

    // Classify this cycle's frame request and precompute capture values.
    always_comb begin
        in_scan_s = 1'b0;
        case (state_r)
            ADDR, CAPTURE, OUT: in_scan_s = 1'b1;
            IDLE, DONE:         in_scan_s = 1'b0;
            default:            in_scan_s = 1'b0;
        endcase
        restart_s     = (state_r == DONE) && (pending_r || frame_complete);
        scan_start_s  = ((state_r == IDLE) && frame_complete) || restart_s;
        pending_set_s = frame_complete && in_scan_s && !pending_r;
        drop_s        = frame_complete && pending_r && (in_scan_s || (state_r == DONE));
        is_last_s     = (x_r == X_LAST) && (page_r == PAGE_LAST);
        addr_s        = ADDR_W'(page_r) * ADDR_W'(WIDTH) + ADDR_W'(x_r);
    end

    // Scan sequencer: address walk, column capture and output handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            x_r        <= 7'd0;
            page_r     <= 3'd0;
            lcd_x_r    <= 7'd0;
            lcd_page_r <= 3'd0;
            data_r     <= 8'd0;
            addr_r     <= '0;
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else if (clk_ce) begin
            case (state_r)
                IDLE: begin
                    if (frame_complete) begin
                        x_r     <= 7'd0;
                        page_r  <= 3'd0;
                        busy_r  <= 1'b1;
                        state_r <= ADDR;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ADDR: begin
                    lcd_x_r    <= x_r;
                    lcd_page_r <= page_r;
                    state_r    <= CAPTURE;
                end
                CAPTURE: begin
                    data_r  <= lcd_read_column;
                    addr_r  <= addr_s;
                    valid_r <= 1'b1;
                    last_r  <= is_last_s;
                    state_r <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        if (last_r) begin
                            state_r <= DONE;
                        end else begin
                            if (x_r == X_LAST) begin
                                x_r    <= 7'd0;
                                page_r <= page_r + 3'd1;
                            end else begin
                                x_r <= x_r + 7'd1;
                            end
                            state_r <= ADDR;
                        end
                    end else begin
                        state_r <= OUT;
                    end
                end
                DONE: begin
                    if (restart_s) begin
                        x_r     <= 7'd0;
                        page_r  <= 3'd0;
                        busy_r  <= 1'b1;
                        state_r <= ADDR;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Queued-frame flag and saturating count of requests that could not be queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r  <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else if (clk_ce) begin
            if (restart_s) begin
                pending_r <= 1'b0;
            end else if (pending_set_s) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
            if (drop_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

`ifdef LCD_SCANOUT_CRC_EN
    logic [7:0] crc_r;
    logic [7:0] crc_next_s;

    lcd_scanout_crc8_update u_crc8 (
        .crc      (crc_r),
        .data     (lcd_read_column),
        .crc_next (crc_next_s)
    );

    // Every captured byte is transferred before the frame ends, so folding at
    // capture time leaves the final CRC ready while the last byte is offered.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_r <= 8'h00;
        end else if (clk_ce) begin
            if (scan_start_s) begin
                crc_r <= 8'h00;
            end else if (state_r == CAPTURE) begin
                crc_r <= crc_next_s;
            end else begin
                crc_r <= crc_r;
            end
        end
    end

    assign frame_crc       = crc_r;
    assign frame_crc_valid = clk_ce && !reset && valid_r && last_r && out_ready;
`endif

endmodule

// File: tb/tb_lcd_scanout.sv
// Scoreboard bench for lcd_scanout: expected byte streams are queued when a
// frame is requested; a monitor pops and compares on every transfer.
module tb_lcd_scanout;

    logic       clk = 1'b0;
    logic       clk_ce = 1'b0;
    logic       reset = 1'b1;
    logic       frame_complete = 1'b0;
    logic       out_ready = 1'b1;
    logic [6:0] lcd_read_x;
    logic [4:0] lcd_read_y;
    logic [7:0] lcd_read_column;
    logic [7:0] out_data;
    logic [9:0] out_addr;
    logic       out_valid;
    logic       out_last;
    logic       busy;
    logic [7:0] frames_dropped;
`ifdef LCD_SCANOUT_CRC_EN
    logic [7:0] frame_crc;
    logic       frame_crc_valid;
`endif

    lcd_scanout dut (
        .clk             (clk),
        .clk_ce          (clk_ce),
        .reset           (reset),
        .frame_complete  (frame_complete),
        .lcd_read_x      (lcd_read_x),
        .lcd_read_y      (lcd_read_y),
        .lcd_read_column (lcd_read_column),
        .out_data        (out_data),
        .out_addr        (out_addr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .busy            (busy),
        .frames_dropped  (frames_dropped)
`ifdef LCD_SCANOUT_CRC_EN
        ,
        .frame_crc       (frame_crc),
        .frame_crc_valid (frame_crc_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        logic       last;
        logic [6:0] x;
        logic [4:0] y;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   xfers = 0;
    int   fc_req = 0;
    bit   rst_req = 1'b1;
    int   ce_div = 1;
    bit   ready_rand = 1'b0;
    int   hold_left = 0;
    int   pat = 0;

    function automatic logic [7:0] pix(input int p, input int x, input int pg);
        logic [7:0] v;
        case (p)
            0:       v = 8'(x ^ (pg << 4));
            1:       v = 8'h00;
            2:       v = (x == 0 && pg == 0) ? 8'h01 : 8'h00;
            default: v = 8'hA5;
        endcase
        return v;
    endfunction

    // Bit-serial reference CRC-8 (poly 0x07, MSB first).
    function automatic logic [7:0] crc8_ref(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    assign lcd_read_column = pix(pat, int'(lcd_read_x), int'(lcd_read_y));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int p);
        exp_t e;
        for (int pg = 0; pg < 8; pg++) begin
            for (int x = 0; x < 96; x++) begin
                e.addr = 10'(pg * 96 + x);
                e.data = pix(p, x, pg);
                e.last = (pg == 7 && x == 95);
                e.x    = 7'(x);
                e.y    = 5'(pg);
                sb.push_back(e);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #4;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((fc_req != 0 || busy || sb.size() != 0) && n < 25000) begin
            tick(1);
            n++;
        end
        if (n >= 25000) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: still busy after %0d clocks, %0d bytes outstanding", name, n, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_xfers(input int target);
        int n = 0;
        while (xfers < target && n < 25000) begin
            tick(1);
            n++;
        end
        if (n >= 25000) begin
            vectors++;
            miscompares++;
            $display("FAIL xfer_wait_timeout: got %0d transfers, expected %0d", xfers, target);
        end
    endtask

    // Input driver: clock enable pattern, frame pulses, reset and sink readiness.
    initial begin : driver
        int ph = 0;
        bit gap = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            clk_ce = (ce_div <= 1) ? 1'b1 : (ph == 0);
            ph = (ce_div <= 1) ? 0 : (ph + 1) % ce_div;
            reset = 1'b0;
            frame_complete = 1'b0;
            if (clk_ce) begin
                if (rst_req) begin
                    reset = 1'b1;
                    rst_req = 1'b0;
                end else if (fc_req > 0 && !gap) begin
                    frame_complete = 1'b1;
                    fc_req--;
                    gap = 1'b1;
                end else begin
                    gap = 1'b0;
                end
                if (hold_left > 0 && out_valid && out_addr == 10'd95) begin
                    out_ready = 1'b0;
                    hold_left--;
                end else if (ready_rand) begin
                    out_ready = 1'($urandom_range(0, 1));
                end else begin
                    out_ready = 1'b1;
                end
            end
        end
    end

    // Monitor: scoreboard pops on transfers, stability while stalled or gated.
    initial begin : monitor
        exp_t       e;
        bit         have_prev = 1'b0;
        bit         prev_ce = 1'b0;
        bit         prev_stall = 1'b0;
        logic [41:0] prev_all = '0;
        logic [41:0] cur_all;
        int         post_last = 0;
        logic [7:0] crc_acc = 8'h00;
        forever begin
            @(negedge clk);
            #3;
            cur_all = {out_valid, out_data, out_addr, out_last, lcd_read_x, lcd_read_y, busy, frames_dropped};
            if (reset) begin
                have_prev = 1'b0;
                post_last = 0;
                crc_acc = 8'h00;
            end else begin
                if (have_prev && !prev_ce) begin
                    chk("hold_ce_low", 32'(cur_all >> 9), 32'(prev_all >> 9));
                    chk("hold_ce_low_status", 32'(cur_all[8:0]), 32'(prev_all[8:0]));
                end
                if (have_prev && prev_ce && prev_stall) begin
                    chk("hold_stall", 32'(cur_all >> 9), 32'(prev_all >> 9));
                end
                if (clk_ce && post_last == 2) begin
                    chk("busy_in_done", 32'(busy), 32'd1);
                    post_last = 1;
                end else if (clk_ce && post_last == 1) begin
                    chk("busy_after_done", 32'(busy), 32'(sb.size() != 0));
                    post_last = 0;
                end
`ifdef LCD_SCANOUT_CRC_EN
                chk("frame_crc_valid", 32'(frame_crc_valid), 32'(clk_ce && out_valid && out_ready && out_last));
`endif
                if (clk_ce && out_valid && out_ready) begin
                    xfers++;
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL xfer: got unexpected byte at addr %0d, expected no transfer", out_addr);
                    end else begin
                        e = sb.pop_front();
                        if (out_addr !== e.addr || out_data !== e.data || out_last !== e.last ||
                            lcd_read_x !== e.x || lcd_read_y !== e.y) begin
                            miscompares++;
                            $display("FAIL xfer: got addr %0d data %02h last %0b x %0d y %0d, expected addr %0d data %02h last %0b x %0d y %0d",
                                     out_addr, out_data, out_last, lcd_read_x, lcd_read_y,
                                     e.addr, e.data, e.last, e.x, e.y);
                        end
                        crc_acc = crc8_ref(crc_acc, e.data);
                        if (e.last) begin
`ifdef LCD_SCANOUT_CRC_EN
                            chk("frame_crc", 32'(frame_crc), 32'(crc_acc));
`endif
                            crc_acc = 8'h00;
                            post_last = 2;
                        end
                    end
                end
                have_prev = 1'b1;
            end
            prev_ce = clk_ce;
            prev_stall = clk_ce && out_valid && !out_ready;
            prev_all = cur_all;
        end
    end

    // Directed sequence.
    initial begin : main
        int base;
        int n;
        tick(3);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames_dropped", 32'(frames_dropped), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_lcd_xy", 32'({lcd_read_x, lcd_read_y}), 32'd0);

        // Basic frame.
        pat = 0;
        push_frame(0);
        fc_req = 1;
        wait_idle("basic");
        chk("basic_count", 32'(xfers), 32'd768);
        chk("basic_busy_idle", 32'(busy), 32'd0);

        // Backpressure with a long stall at addr 95.
        ready_rand = 1'b1;
        hold_left = 20;
        push_frame(0);
        fc_req = 1;
        wait_idle("backpressure");
        ready_rand = 1'b0;
        chk("stall_applied", 32'(hold_left), 32'd0);

        // Start + one queued + one dropped request.
        base = xfers;
        push_frame(0);
        push_frame(0);
        fc_req = 1;
        wait_xfers(base + 50);
        fc_req = 2;
        wait_idle("pending");
        chk("pending_count", 32'(xfers - base), 32'd1536);
        chk("dropped_one", 32'(frames_dropped), 32'd1);

        // Drop counter saturation.
        push_frame(0);
        push_frame(0);
        fc_req = 1;
        wait_xfers(xfers + 20);
        fc_req = 301;
        wait_idle("saturate");
        chk("dropped_sat", 32'(frames_dropped), 32'd255);

        // Reset in the middle of a scan.
        base = xfers;
        push_frame(0);
        fc_req = 1;
        wait_xfers(base + 400);
        rst_req = 1'b1;
        n = 0;
        while (!reset && n < 20) begin
            tick(1);
            n++;
        end
        sb.delete();
        tick(1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_dropped", 32'(frames_dropped), 32'd0);
        chk("midrst_count", 32'(xfers - base), 32'd400);
        push_frame(0);
        fc_req = 1;
        wait_idle("after_reset");

        // Clock enable high one cycle in four.
        ce_div = 4;
        base = xfers;
        push_frame(0);
        fc_req = 1;
        wait_idle("ce_gated");
        chk("ce_gated_count", 32'(xfers - base), 32'd768);
        ce_div = 1;

`ifdef LCD_SCANOUT_CRC_EN
        pat = 1;
        push_frame(1);
        fc_req = 1;
        wait_idle("crc_zero");
        chk("crc_zero_frame", 32'(frame_crc), 32'h00);
        pat = 2;
        push_frame(2);
        fc_req = 1;
        wait_idle("crc_one");
`endif

        tick(5);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
